// File: rtl/readout_seq.sv
// readout_seq: row-readout sequencer driving per-row precharge/sample/convert phases
// Ports:
//   CLK, rst_n        clock, asynchronous active-low reset
//   trigger_i         single-cycle frame start from the exposure block
//   NUM_ROW           rows per frame (clamped to 2**ROW_W)
//   T1..T6            phase durations in CLK cycles (0 behaves as 1)
//   re_busy           high from frame start to frame end
//   ROWADD            current readout row
//   PRECH_COL, SAMP_R, PGA_RES, SAMP_S, READ   mutually exclusive phase outputs
//   MUX_START         first CONV cycle, ADC_DATA_VALID last CONV cycle
//   overrun           sticky, trigger seen while busy
module readout_seq #(
    parameter int ROW_W = 9,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             trigger_i,
    input  logic [9:0]       NUM_ROW,
    input  logic [CNT_W-1:0] T1,
    input  logic [CNT_W-1:0] T2,
    input  logic [CNT_W-1:0] T3,
    input  logic [CNT_W-1:0] T4,
    input  logic [CNT_W-1:0] T5,
    input  logic [CNT_W-1:0] T6,
    output logic             re_busy,
    output logic [ROW_W-1:0] ROWADD,
    output logic             PRECH_COL,
    output logic             SAMP_R,
    output logic             PGA_RES,
    output logic             SAMP_S,
    output logic             READ,
    output logic             MUX_START,
    output logic             ADC_DATA_VALID,
    output logic             overrun
);
    typedef enum logic [2:0] {IDLE, PRECH, SETTLE, SAMPR, PGARES, SAMPS, CONV, DONE} state_t;
    localparam logic [9:0] MAX_ROWS = 10'(1 << ROW_W);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cur_t;
    logic [CNT_W-1:0] t_q [6];
    logic [CNT_W-1:0] t_d [6];
    logic [9:0]       rows_q, rows_d, num_clamped;
    logic [ROW_W-1:0] row_q, row_d;
    logic             phase_end, last_row, start;
    logic             busy_q, busy_d, prech_q, prech_d, sampr_q, sampr_d, pgares_q, pgares_d;
    logic             samps_q, samps_d, read_q, read_d, mux_q, mux_d, adv_q, adv_d;
    logic             overrun_q, overrun_d;

    assign num_clamped = NUM_ROW > MAX_ROWS ? MAX_ROWS : NUM_ROW;
    assign start       = state_q == IDLE && trigger_i;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A phase ends once it has spent max(T,1) cycles, so T=0 and T=1 both end at cnt 0.
    always_comb begin
        cur_t = '0;
        case (state_q)
            PRECH:   cur_t = t_q[0];
            SETTLE:  cur_t = t_q[1];
            SAMPR:   cur_t = t_q[2];
            PGARES:  cur_t = t_q[3];
            SAMPS:   cur_t = t_q[4];
            CONV:    cur_t = t_q[5];
            default: cur_t = '0;
        endcase
        phase_end = cnt_q + CNT_W'(1) >= cur_t;
        last_row  = 10'(row_q) + 10'd1 >= rows_q;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (trigger_i) state_d = num_clamped == '0 ? DONE : PRECH;
            PRECH:   if (phase_end) state_d = SETTLE;
            SETTLE:  if (phase_end) state_d = SAMPR;
            SAMPR:   if (phase_end) state_d = PGARES;
            PGARES:  if (phase_end) state_d = SAMPS;
            SAMPS:   if (phase_end) state_d = CONV;
            CONV:    if (phase_end) state_d = last_row ? DONE : PRECH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        rows_d = start ? num_clamped : rows_q;
        t_d[0] = start ? T1 : t_q[0];
        t_d[1] = start ? T2 : t_q[1];
        t_d[2] = start ? T3 : t_q[2];
        t_d[3] = start ? T4 : t_q[3];
        t_d[4] = start ? T5 : t_q[4];
        t_d[5] = start ? T6 : t_q[5];
        row_d  = start ? '0 : (state_q == CONV && state_d == PRECH) ? row_q + ROW_W'(1) : row_q;
    end

    // Outputs decode the next state so every output is a flop aligned with its state.
    always_comb begin
        busy_d    = state_d != IDLE;
        prech_d   = state_d == PRECH;
        sampr_d   = state_d == SAMPR;
        pgares_d  = state_d == PGARES;
        samps_d   = state_d == SAMPS;
        read_d    = state_d == CONV;
        mux_d     = state_d == CONV && cnt_d == '0;
        adv_d     = state_d == CONV && cnt_d + CNT_W'(1) >= t_q[5];
        overrun_d = overrun_q | (trigger_i && state_q != IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rows_q    <= '0;
            row_q     <= '0;
            for (int i = 0; i < 6; i++) t_q[i] <= '0;
            busy_q    <= 1'b0;
            prech_q   <= 1'b0;
            sampr_q   <= 1'b0;
            pgares_q  <= 1'b0;
            samps_q   <= 1'b0;
            read_q    <= 1'b0;
            mux_q     <= 1'b0;
            adv_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rows_q    <= rows_d;
            row_q     <= row_d;
            for (int i = 0; i < 6; i++) t_q[i] <= t_d[i];
            busy_q    <= busy_d;
            prech_q   <= prech_d;
            sampr_q   <= sampr_d;
            pgares_q  <= pgares_d;
            samps_q   <= samps_d;
            read_q    <= read_d;
            mux_q     <= mux_d;
            adv_q     <= adv_d;
            overrun_q <= overrun_d;
        end
    end

    assign re_busy        = busy_q;
    assign ROWADD         = row_q;
    assign PRECH_COL      = prech_q;
    assign SAMP_R         = sampr_q;
    assign PGA_RES        = pgares_q;
    assign SAMP_S         = samps_q;
    assign READ           = read_q;
    assign MUX_START      = mux_q;
    assign ADC_DATA_VALID = adv_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_readout_seq.sv
// tb_readout_seq: scoreboard bench for readout_seq, one expected record per frame
module tb_readout_seq;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger_i = 1'b0;
    logic [9:0]  NUM_ROW = '0;
    logic [31:0] T1 = '0, T2 = '0, T3 = '0, T4 = '0, T5 = '0, T6 = '0;
    logic        re_busy, PRECH_COL, SAMP_R, PGA_RES, SAMP_S, READ, MUX_START, ADC_DATA_VALID, overrun;
    logic [8:0]  ROWADD;

    readout_seq #(.ROW_W(9), .CNT_W(32)) dut (
        .CLK(CLK), .rst_n(rst_n), .trigger_i(trigger_i), .NUM_ROW(NUM_ROW),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6),
        .re_busy(re_busy), .ROWADD(ROWADD), .PRECH_COL(PRECH_COL), .SAMP_R(SAMP_R),
        .PGA_RES(PGA_RES), .SAMP_S(SAMP_S), .READ(READ), .MUX_START(MUX_START),
        .ADC_DATA_VALID(ADC_DATA_VALID), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int busy, max_row, steps, prech, prech_p, sampr, pga, samps, rd, mux, adv, coinc, excl;
    } frame_t;

    frame_t exp_q[$];
    frame_t act, e;
    int     n_pass = 0, n_tot = 0;
    int     prev_busy = 0, prev_prech = 0;
    int     prev_row = 0;

    task automatic chk(input string nm, input int got, input int req);
        n_tot++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, req);
    endtask

    function automatic int dur(input int t);
        return t == 0 ? 1 : t;
    endfunction

    function automatic frame_t model(input int n, input int t1, input int t2, input int t3,
                                     input int t4, input int t5, input int t6);
        frame_t f;
        int r;
        r = n > 512 ? 512 : n;
        f.busy    = r * (dur(t1) + dur(t2) + dur(t3) + dur(t4) + dur(t5) + dur(t6)) + 1;
        f.max_row = r == 0 ? 0 : r - 1;
        f.steps   = r == 0 ? 0 : r - 1;
        f.prech   = r * dur(t1);
        f.prech_p = r;
        f.sampr   = r * dur(t3);
        f.pga     = r * dur(t4);
        f.samps   = r * dur(t5);
        f.rd      = r * dur(t6);
        f.mux     = r;
        f.adv     = r;
        f.coinc   = dur(t6) == 1 ? r : 0;
        f.excl    = 0;
        return f;
    endfunction

    // Monitor: accumulates one frame of activity, compares when re_busy falls.
    always @(negedge CLK) begin
        if (!rst_n) begin
            act = '{default: 0};
            prev_busy = 0;
            prev_prech = 0;
        end else begin
            if (re_busy) begin
                if (prev_busy != 0 && int'(ROWADD) != prev_row) act.steps++;
                if (int'(ROWADD) > act.max_row) act.max_row = int'(ROWADD);
                prev_row = int'(ROWADD);
                act.busy++;
            end
            act.prech += int'(PRECH_COL);
            act.sampr += int'(SAMP_R);
            act.pga   += int'(PGA_RES);
            act.samps += int'(SAMP_S);
            act.rd    += int'(READ);
            act.mux   += int'(MUX_START);
            act.adv   += int'(ADC_DATA_VALID);
            if (MUX_START && ADC_DATA_VALID) act.coinc++;
            if (PRECH_COL && prev_prech == 0) act.prech_p++;
            prev_prech = int'(PRECH_COL);
            if ($countones({PRECH_COL, SAMP_R, PGA_RES, SAMP_S, READ}) > 1 ||
                (!re_busy && (PRECH_COL || SAMP_R || PGA_RES || SAMP_S || READ || MUX_START || ADC_DATA_VALID)))
                act.excl++;
            if (prev_busy != 0 && !re_busy) begin
                if (exp_q.size() == 0) chk("spurious_frame", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("busy_cycles", act.busy, e.busy);
                    chk("max_rowadd", act.max_row, e.max_row);
                    chk("row_steps", act.steps, e.steps);
                    chk("prech_cycles", act.prech, e.prech);
                    chk("prech_pulses", act.prech_p, e.prech_p);
                    chk("samp_r_cycles", act.sampr, e.sampr);
                    chk("pga_res_cycles", act.pga, e.pga);
                    chk("samp_s_cycles", act.samps, e.samps);
                    chk("read_cycles", act.rd, e.rd);
                    chk("mux_start_pulses", act.mux, e.mux);
                    chk("adc_valid_pulses", act.adv, e.adv);
                    chk("mux_adv_coincident", act.coinc, e.coinc);
                    chk("exclusivity", act.excl, e.excl);
                end
                act = '{default: 0};
            end
            prev_busy = int'(re_busy);
        end
    end

    task automatic set_t(input int a, input int b, input int c, input int d, input int f, input int g);
        T1 = a; T2 = b; T3 = c; T4 = d; T5 = f; T6 = g;
    endtask

    // Called just after a rising edge; trigger is sampled at the next rising edge.
    task automatic fire(input int n, input bit push);
        NUM_ROW = 10'(n);
        trigger_i = 1'b1;
        if (push) exp_q.push_back(model(n, int'(T1), int'(T2), int'(T3), int'(T4), int'(T5), int'(T6)));
        @(posedge CLK);
        #1 trigger_i = 1'b0;
    endtask

    task automatic start(input int n);
        @(posedge CLK);
        #1 fire(n, 1'b1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        chk("frame_completed", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic int outs();
        return int'({re_busy, ROWADD, PRECH_COL, SAMP_R, PGA_RES, SAMP_S, READ,
                     MUX_START, ADC_DATA_VALID, overrun});
    endfunction

    initial begin
        int w;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_outputs", outs(), 0);

        set_t(100, 20, 10, 40, 30, 10);
        start(4);
        wait_done(2000);
        chk("rowadd_hold", int'(ROWADD), 3);
        chk("overrun_clear", int'(overrun), 0);

        set_t(0, 0, 0, 0, 0, 0);
        start(2);
        wait_done(100);

        set_t(3, 3, 3, 3, 3, 3);
        start(0);
        wait_done(50);

        set_t(0, 0, 0, 0, 0, 0);
        start(700);
        wait_done(5000);
        chk("rowadd_clamped", int'(ROWADD), 511);

        set_t(4, 2, 6, 3, 2, 3);
        start(2);
        repeat (10) @(posedge CLK);
        #1 T3 = 20;
        wait_done(200);

        set_t(5, 5, 5, 5, 5, 5);
        start(3);
        repeat (18) @(posedge CLK);
        #1 trigger_i = 1'b1;
        @(posedge CLK);
        #1 trigger_i = 1'b0;
        wait_done(300);
        chk("overrun_set", int'(overrun), 1);
        chk("rowadd_overrun_frame", int'(ROWADD), 2);
        start(1);
        wait_done(100);
        chk("overrun_sticky", int'(overrun), 1);

        @(posedge CLK);
        #1 fire(3, 1'b0);
        repeat (49) @(posedge CLK);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1 chk("post_reset_idle", outs(), 0);

        set_t(2, 1, 3, 1, 2, 2);
        start(2);
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (re_busy && w < 200) begin
                @(posedge CLK);
                #1 w++;
            end
            chk("busy_drop", int'(re_busy), 0);
            fire(2, 1'b1);
        end
        wait_done(200);
        chk("no_overrun_back_to_back", int'(overrun), 0);

        repeat (5) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
